// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the CORDIC vectoring datapath.
//   - Default widths: W (magnitude / X width), FRAC (fractional bits),
//     ZW (angle word width), GUARD (extra internal LSBs).
//   - Shift-add approximation of the CORDIC gain compensation constant:
//       K_approx = 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13 = 0.6072998
//     The terms are listed by k_shift(i), and bit i of K_NEG marks a
//     subtracted term.
//   - fx_s1_12_t: S1.12 two's complement fixed-point word, shared with the
//     micro-rotation stages.
// -----------------------------------------------------------------------------
package cordic_pkg;

    localparam int W_DEF     = 14;
    localparam int FRAC_DEF  = 12;
    localparam int ZW_DEF    = 16;
    localparam int GUARD_DEF = 4;

    // Shift-add terms of K_approx.
    localparam int              K_TERMS = 5;
    localparam logic [K_TERMS-1:0] K_NEG = 5'b11100;  // terms 2..4 are subtracted

    function automatic int k_shift(input int idx);
        case (idx)
            0:       return 1;
            1:       return 3;
            2:       return 6;
            3:       return 9;
            default: return 13;
        endcase
    endfunction

    typedef logic signed [W_DEF-1:0] fx_s1_12_t;

endpackage

// File: rtl/cordic_pipe_reg.sv
// -----------------------------------------------------------------------------
// cordic_pipe_reg
// Generic one-entry valid/ready register slice with full-throughput
// backpressure: a new beat may be loaded in the same cycle the held beat
// leaves. in_ready depends combinationally on out_ready; out_valid and
// out_data come straight from flops.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake
//   in_data  [PW]         upstream payload
//   out_valid / out_ready downstream handshake
//   out_data [PW]         registered payload
// -----------------------------------------------------------------------------
module cordic_pipe_reg #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data
);

    logic          valid_q, valid_d;
    logic [PW-1:0] data_q,  data_d;

    // The slot is free when empty or when its current beat leaves this cycle.
    assign in_ready = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/cordic_post_scale.sv
// -----------------------------------------------------------------------------
// cordic_post_scale
// Output stage after the last CORDIC vectoring micro-rotation. Removes the
// CORDIC gain from X by multiplying with K_approx (shift-add) and presents
// magnitude and angle on a 2-stage valid/ready pipeline.
//   S1: pa = (x>>1)+(x>>3), pb = (x>>6)+(x>>9)+(x>>13), sign flag, z.
//   S2: r = pa - pb, drop GUARD LSBs, force 0 + neg_err on negative input.
// Configuration macro: CORDIC_POST_SCALE_RND_EN
//   defined   -> round half up when dropping GUARD bits
//   undefined -> truncate (floor)
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  upstream handshake
//   x_in  [W]            final X, S1.12 two's complement
//   z_in  [ZW]           accumulated angle, passed through
//   out_valid / out_ready downstream handshake
//   mag   [W]            scaled magnitude, S1.12, never negative
//   z_out [ZW]           z_in aligned with mag
//   neg_err              x_in was negative; mag forced to 0
// -----------------------------------------------------------------------------
module cordic_post_scale
    import cordic_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int ZW    = ZW_DEF,
    parameter int GUARD = GUARD_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  x_in,
    input  logic [ZW-1:0] z_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  mag,
    output logic [ZW-1:0] z_out,
    output logic          neg_err
);

    // The datapath assumes a single integer bit above the sign (S1.FRAC).
    if (FRAC != W - 2) begin : g_fmt_check
        $error("cordic_post_scale: FRAC must equal W-2");
    end

    localparam int IW  = W + GUARD + 1;       // internal signed width
    localparam int S1W = 2 * IW + 1 + ZW;     // {pa, pb, neg, z}
    localparam int S2W = W + 1 + ZW;          // {mag, neg_err, z}

    // ---------------------------------------------------------------- S1 ---
    logic signed [IW-1:0] x_ext;
    logic signed [IW-1:0] pa_d, pb_d;
    logic signed [IW-1:0] term [K_TERMS];

    // x_in sign-extended by one bit and padded with GUARD zero LSBs so the
    // shifted-out fraction of each term is partly retained.
    assign x_ext = {x_in[W-1], x_in, {GUARD{1'b0}}};

    for (genvar gi = 0; gi < K_TERMS; gi++) begin : g_terms
        assign term[gi] = x_ext >>> k_shift(gi);
    end

    always_comb begin
        pa_d = '0;
        pb_d = '0;
        for (int i = 0; i < K_TERMS; i++) begin
            if (K_NEG[i]) begin
                pb_d = pb_d + term[i];
            end else begin
                pa_d = pa_d + term[i];
            end
        end
    end

    logic           s1_valid, s1_ready;
    logic [S1W-1:0] s1_data;
    logic           s2_in_ready;

    cordic_pipe_reg #(.PW(S1W)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (s1_ready),
        .in_data   ({pa_d, pb_d, x_in[W-1], z_in}),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready),
        .out_data  (s1_data)
    );

    assign in_ready = s1_ready;

    // ---------------------------------------------------------------- S2 ---
    logic signed [IW-1:0] s1_pa, s1_pb;
    logic                 s1_neg;
    logic [ZW-1:0]        s1_z;
    logic signed [IW-1:0] r_raw, r_adj;
    logic [W-1:0]         mag_d;

    assign {s1_pa, s1_pb, s1_neg, s1_z} = s1_data;
    assign r_raw = s1_pa - s1_pb;

`ifdef CORDIC_POST_SCALE_RND_EN
    assign r_adj = r_raw + (IW'(1) << (GUARD - 1));
`else
    assign r_adj = r_raw;
`endif

    // K < 1, so a non-negative result always fits W bits after the drop.
    assign mag_d = s1_neg ? '0 : r_adj[GUARD +: W];

    // Bits of r_adj outside the magnitude field carry no information here.
    logic unused_r_bits;
    assign unused_r_bits = ^{r_adj[IW-1:GUARD+W], r_adj[GUARD-1:0]};

    logic [S2W-1:0] s2_data;

    cordic_pipe_reg #(.PW(S2W)) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_data   ({mag_d, s1_neg, s1_z}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_data)
    );

    assign {mag, neg_err, z_out} = s2_data;

endmodule

// File: tb/tb_cordic_post_scale.sv
module tb_cordic_post_scale;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] x_in;
    logic [15:0] z_in;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] mag;
    logic [15:0] z_out;
    logic        neg_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cordic_post_scale dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag       (mag),
        .z_out     (z_out),
        .neg_err   (neg_err)
    );

    // Reference: X * K_approx with each term floor(X*16 / 2^s), then drop 4 guard bits.
    function automatic logic [13:0] model_mag(input logic [13:0] x);
        int xv;
        int r;
        if (x[13]) return 14'd0;
        xv = int'(x) * 16;
        r  = xv / 2 + xv / 8 - (xv / 64 + xv / 512 + xv / 8192);
`ifdef CORDIC_POST_SCALE_RND_EN
        r  = r + 8;
`endif
        return 14'(r / 16);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; x_in = 14'h1000; z_in = 16'h1234; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || mag !== 14'h0 || z_out !== 16'h0 || neg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b mag=%h z=%h neg=%b, want 0/0/0/0", out_valid, mag, z_out, neg_err);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
        $display("[TB] reset: checked idle outputs and in_ready after release");
    endtask

    task automatic test_unit_gain();
        logic [13:0] exp_mag;
`ifdef CORDIC_POST_SCALE_RND_EN
        exp_mag = 14'h09B8;
`else
        exp_mag = 14'h09B7;
`endif
        @(negedge clk);
        in_valid = 1'b1; x_in = 14'h1000; z_in = 16'h1234; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL unit_gain_latency1: out_valid=%b after 1 cycle, want 0", out_valid);
        end
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b1 || mag !== exp_mag || z_out !== 16'h1234 || neg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL unit_gain: got v=%b mag=%h z=%h neg=%b, want 1/%h/1234/0", out_valid, mag, z_out, neg_err, exp_mag);
        end
        $display("[TB] unit_gain: x=1000 -> mag=%h z=%h", mag, z_out);
        @(negedge clk);
    endtask

    task automatic test_limits();
        logic [13:0] xs [4];
        logic [13:0] em [4];
        logic        en [4];
        int          waited;
        xs[0] = 14'h1FFF; en[0] = 1'b0;
`ifdef CORDIC_POST_SCALE_RND_EN
        em[0] = 14'h136F;
`else
        em[0] = 14'h136E;
`endif
        xs[1] = 14'h0000; em[1] = 14'h0000; en[1] = 1'b0;
        xs[2] = 14'h3000; em[2] = 14'h0000; en[2] = 1'b1;
        xs[3] = 14'h2000; em[3] = 14'h0000; en[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; x_in = xs[i]; z_in = 16'(16'hA000 + i); out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            waited = 0;
            while (out_valid !== 1'b1 && waited < 5) begin
                @(posedge clk); #1;
                waited++;
            end
            n_tests++;
            if (out_valid !== 1'b1 || mag !== em[i] || neg_err !== en[i] || z_out !== 16'(16'hA000 + i)) begin
                n_fail++;
                $display("FAIL limit_%0d: x=%h got v=%b mag=%h neg=%b z=%h, want 1/%h/%b/%h",
                         i, xs[i], out_valid, mag, neg_err, z_out, em[i], en[i], 16'(16'hA000 + i));
            end
            $display("[TB] limit: x=%h -> mag=%h neg_err=%b", xs[i], mag, neg_err);
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [13:0] xs [3];
        int          accepted;
        int          got;
        int          cyc;
        logic [13:0] held_mag;
        xs[0] = 14'h0100; xs[1] = 14'h0200; xs[2] = 14'h0300;
        accepted = 0;
        held_mag = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            x_in      = xs[accepted];
            z_in      = 16'(accepted);
            #1;
            if (c == 3) begin
                n_tests++;
                if (mag !== held_mag || out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_hold: mag=%h v=%b, want %h/1", mag, out_valid, held_mag);
                end
            end
            held_mag = mag;
            if (in_valid && in_ready) accepted++;
        end
        n_tests++;
        if (accepted != 2 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: accepted=%0d in_ready=%b, want 2/0", accepted, in_ready);
        end
        got = 0;
        cyc = 0;
        while (got < 3 && cyc < 12) begin
            if (cyc > 0) @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (accepted < 3);
            if (accepted < 3) begin
                x_in = xs[accepted];
                z_in = 16'(accepted);
            end
            #1;
            if (out_valid && out_ready) begin
                n_tests++;
                if (mag !== model_mag(xs[got]) || z_out !== 16'(got)) begin
                    n_fail++;
                    $display("FAIL bp_order_%0d: mag=%h z=%h, want %h/%h", got, mag, z_out, model_mag(xs[got]), 16'(got));
                end
                $display("[TB] backpressure: out #%0d mag=%h z=%h", got, mag, z_out);
                got++;
            end
            if (in_valid && in_ready) accepted++;
            cyc++;
            if (cyc == 1) @(posedge clk);
            else @(posedge clk);
        end
        n_tests++;
        if (got != 3) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d results, want 3", got);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_midflight_reset();
        int seen;
        int waited;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; x_in = 14'h0400; z_in = 16'h0BAD;
        @(negedge clk);
        x_in = 14'h0600; z_in = 16'h0BEE;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_full: out_valid=%b in_ready=%b, want 1/0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || mag !== 14'h0 || z_out !== 16'h0) begin
            n_fail++;
            $display("FAIL mid_async: out_valid=%b mag=%h z=%h, want 0/0/0", out_valid, mag, z_out);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (out_valid) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL mid_stale: %0d stale outputs, want 0", seen);
        end
        @(negedge clk);
        in_valid = 1'b1; x_in = 14'h0800; z_in = 16'h55AA;
        @(posedge clk); #1;
        in_valid = 1'b0;
        waited = 0;
        while (out_valid !== 1'b1 && waited < 5) begin
            @(posedge clk); #1;
            waited++;
        end
        n_tests++;
        if (out_valid !== 1'b1 || mag !== model_mag(14'h0800) || z_out !== 16'h55AA) begin
            n_fail++;
            $display("FAIL mid_first: v=%b mag=%h z=%h, want 1/%h/55aa", out_valid, mag, z_out, model_mag(14'h0800));
        end
        $display("[TB] midflight_reset: first post-reset out mag=%h z=%h", mag, z_out);
        @(negedge clk);
    endtask

    task automatic test_random_stream();
        logic [13:0] q_mag [$];
        logic [15:0] q_z   [$];
        logic        q_neg [$];
        int          sent, got, cyc, errs_before;
        logic        hold_prev;
        logic [13:0] pm;
        logic [15:0] pz;
        logic        pn;
        logic [13:0] em;
        logic [15:0] ez;
        logic        en;
        sent = 0; got = 0; cyc = 0; hold_prev = 1'b0;
        pm = '0; pz = '0; pn = 1'b0;
        errs_before = n_fail;
        while ((sent < 10000 || q_mag.size() > 0) && cyc < 60000) begin
            @(negedge clk);
            in_valid  = (sent < 10000) && ($urandom_range(0, 9) < 7);
            x_in      = 14'($urandom_range(0, 16383));
            z_in      = 16'($urandom_range(0, 65535));
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (hold_prev) begin
                n_tests++;
                if (out_valid !== 1'b1 || mag !== pm || z_out !== pz || neg_err !== pn) begin
                    n_fail++;
                    $display("FAIL rand_hold: v=%b mag=%h z=%h neg=%b, want 1/%h/%h/%b", out_valid, mag, z_out, neg_err, pm, pz, pn);
                end
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (q_mag.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_spurious: output mag=%h with empty scoreboard", mag);
                end else begin
                    em = q_mag.pop_front(); ez = q_z.pop_front(); en = q_neg.pop_front();
                    if (mag !== em || z_out !== ez || neg_err !== en) begin
                        n_fail++;
                        $display("FAIL rand_beat_%0d: mag=%h z=%h neg=%b, want %h/%h/%b", got, mag, z_out, neg_err, em, ez, en);
                    end
                    got++;
                end
            end
            hold_prev = out_valid && !out_ready;
            pm = mag; pz = z_out; pn = neg_err;
            if (in_valid && in_ready) begin
                q_mag.push_back(model_mag(x_in));
                q_z.push_back(z_in);
                q_neg.push_back(x_in[13]);
                sent++;
            end
            cyc++;
        end
        n_tests++;
        if (cyc >= 60000 || got != 10000) begin
            n_fail++;
            $display("FAIL rand_complete: sent=%0d got=%0d cycles=%0d, want 10000 received", sent, got, cyc);
        end
        $display("[TB] random_stream: %0d beats sent, %0d received, %0d new errors", sent, got, n_fail - errs_before);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_unit_gain();
        test_limits();
        test_backpressure();
        test_midflight_reset();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
